// File: rtl/pcie_datalink_pkg.sv
// Shared datalink-layer types: TX scheduler FSM states and source index assignments.
package pcie_datalink_pkg;

  typedef enum logic [0:0] {
    SCHED_IDLE,
    SCHED_XFER
  } dl_sched_state_e;

  localparam int DL_SRC_ACKNAK = 0;
  localparam int DL_SRC_FC     = 1;
  localparam int DL_SRC_TLP    = 2;

endpackage

// File: rtl/pcie_dl_sched_age.sv
// Per-source saturating wait counter; raises aged_o once the source has waited STARVE_LIMIT cycles.
module pcie_dl_sched_age #(
  parameter int STARVE_LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic elig_i,
  input  logic granted_i,
  input  logic win_i,
  output logic aged_o
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_q;

  // Winning or being disabled restarts the wait; otherwise count waiting cycles up to the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      age_q <= '0;
    end else if (!en_i || win_i) begin
      age_q <= '0;
    end else if (elig_i && !granted_i && (age_q != AGE_MAX)) begin
      age_q <= age_q + AGE_W'(1);
    end
  end

  assign aged_o = (age_q == AGE_MAX);

endmodule

// File: rtl/pcie_dl_tx_scheduler.sv
// Packet-atomic fixed-priority TX scheduler with aging and a registered AXIS output stage.
// Optional per-source packet statistics enabled by defining PCIE_DL_SCHED_STATS_EN.
module pcie_dl_tx_scheduler
  import pcie_datalink_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 3,
  parameter int S_COUNT      = 3,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_en_i,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic [S_COUNT-1:0]            grant_o,
  output logic                          busy_o
`ifdef PCIE_DL_SCHED_STATS_EN
  ,
  output logic [S_COUNT*16-1:0]         stat_pkt_cnt_o,
  input  logic                          stat_clr_i
`endif
);

  dl_sched_state_e state_q, state_d;
  logic [S_COUNT-1:0] grant_d;
  logic [S_COUNT-1:0] eligible;
  logic [S_COUNT-1:0] aged;
  logic [S_COUNT-1:0] aged_elig;
  logic [S_COUNT-1:0] pick;
  logic [S_COUNT-1:0] winner_oh;
  logic [S_COUNT-1:0] win;

  logic                  out_rdy;
  logic                  accept;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [USER_WIDTH-1:0] sel_user;

  // Aged sources preempt plain priority; x & -x isolates the lowest-index candidate.
  assign eligible  = s_axis_tvalid & s_en_i;
  assign aged_elig = eligible & aged;
  assign pick      = (|aged_elig) ? aged_elig : eligible;
  assign winner_oh = pick & (~pick + S_COUNT'(1));

  assign out_rdy       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = ((state_q == SCHED_XFER) && out_rdy) ? grant_o : '0;
  assign accept        = (state_q == SCHED_XFER) && sel_valid && out_rdy;
  assign busy_o        = (state_q == SCHED_XFER);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_o[i]) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // Grant is only picked in IDLE and only released on an accepted tlast beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_o;
    win     = '0;
    case (state_q)
      SCHED_IDLE: begin
        if (|eligible) begin
          state_d = SCHED_XFER;
          grant_d = winner_oh;
          win     = winner_oh;
        end
      end
      SCHED_XFER: begin
        if (accept && sel_last) begin
          state_d = SCHED_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = SCHED_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SCHED_IDLE;
      grant_o <= '0;
    end else begin
      state_q <= state_d;
      grant_o <= grant_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= sel_last;
      m_axis_tdata  <= sel_data;
      m_axis_tkeep  <= sel_keep;
      m_axis_tuser  <= sel_user;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  for (genvar g = 0; g < S_COUNT; g++) begin : g_age
    pcie_dl_sched_age #(
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_age (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (s_en_i[g]),
      .elig_i   (eligible[g]),
      .granted_i(grant_o[g]),
      .win_i    (win[g]),
      .aged_o   (aged[g])
    );
  end

`ifdef PCIE_DL_SCHED_STATS_EN
  for (genvar g = 0; g < S_COUNT; g++) begin : g_stat
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stat_pkt_cnt_o[g*16 +: 16] <= '0;
      end else if (stat_clr_i) begin
        stat_pkt_cnt_o[g*16 +: 16] <= '0;
      end else if (accept && sel_last && grant_o[g]) begin
        stat_pkt_cnt_o[g*16 +: 16] <= stat_pkt_cnt_o[g*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pcie_dl_tx_scheduler.sv
// Scoreboard bench for pcie_dl_tx_scheduler (STARVE_LIMIT=4); stats checks follow PCIE_DL_SCHED_STATS_EN.
module tb_pcie_dl_tx_scheduler;
  import pcie_datalink_pkg::*;

  localparam int S  = 3;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [S*DW-1:0] s_tdata;
  logic [S*KW-1:0] s_tkeep;
  logic [S-1:0]    s_tvalid;
  logic [S-1:0]    s_tlast;
  logic [S*UW-1:0] s_tuser;
  logic [S-1:0]    s_tready;
  logic [S-1:0]    s_en;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tlast;
  logic [UW-1:0]   m_tuser;
  logic            m_tready;
  logic [S-1:0]    grant;
  logic            busy;
`ifdef PCIE_DL_SCHED_STATS_EN
  logic [S*16-1:0] stat_cnt;
  logic            stat_clr;
`endif

  logic [DW-1:0] drv_data  [S];
  logic [KW-1:0] drv_keep  [S];
  logic [UW-1:0] drv_user  [S];
  logic          drv_valid [S];
  logic          drv_last  [S];

  beat_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pcie_dl_tx_scheduler #(
    .DATA_WIDTH  (DW),
    .KEEP_WIDTH  (KW),
    .USER_WIDTH  (UW),
    .S_COUNT     (S),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tuser (s_tuser),
    .s_axis_tready(s_tready),
    .s_en_i       (s_en),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser),
    .m_axis_tready(m_tready),
    .grant_o      (grant),
    .busy_o       (busy)
`ifdef PCIE_DL_SCHED_STATS_EN
    ,
    .stat_pkt_cnt_o(stat_cnt),
    .stat_clr_i    (stat_clr)
`endif
  );

  always_comb begin
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int i = 0; i < S; i++) begin
      s_tdata[i*DW +: DW] = drv_data[i];
      s_tkeep[i*KW +: KW] = drv_keep[i];
      s_tuser[i*UW +: UW] = drv_user[i];
      s_tvalid[i]         = drv_valid[i];
      s_tlast[i]          = drv_last[i];
    end
  end

  function automatic beat_t mkBeat(input int src, input int pkt, input int b, input int n);
    beat_t r;
    r.data = {4'hA, 4'(src), 8'(pkt), 16'(b)};
    r.keep = (b == n - 1) ? 4'h3 : 4'hF;
    r.user = 3'(src + b);
    r.last = (b == n - 1);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushPacket(input int src, input int n, input int pkt);
    for (int b = 0; b < n; b++) exp_q.push_back(mkBeat(src, pkt, b, n));
  endtask

  // Drives one packet on a source; aborts on reset or after a bounded wait.
  task automatic applyStimulus(input int src, input int n, input int pkt);
    beat_t bt;
    logic  rdy;
    int    cycles;
    for (int b = 0; b < n; b++) begin
      bt = mkBeat(src, pkt, b, n);
      drv_data[src]  = bt.data;
      drv_keep[src]  = bt.keep;
      drv_user[src]  = bt.user;
      drv_last[src]  = bt.last;
      drv_valid[src] = 1'b1;
      cycles = 0;
      do begin
        @(negedge clk);
        rdy = s_tready[src];
        tick();
        cycles++;
        if (rst) begin
          drv_valid[src] = 1'b0;
          drv_last[src]  = 1'b0;
          return;
        end
        if (cycles > 200) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL handshake_timeout: src %0d pkt %0d beat %0d got no ready, required ready", src, pkt, b);
          drv_valid[src] = 1'b0;
          return;
        end
      end while (!rdy);
    end
    drv_valid[src] = 1'b0;
    drv_last[src]  = 1'b0;
  endtask

  task automatic settle();
    repeat (4) tick();
    s_en = '0;
    tick();
    s_en = '1;
    tick();
  endtask

  // Monitor: every beat the PHY takes must be the next expected one.
  initial begin
    beat_t act;
    beat_t exp;
    forever begin
      @(negedge clk);
      if (!rst && m_tvalid && m_tready) begin
        act = {m_tdata, m_tkeep, m_tuser, m_tlast};
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'(act), 64'(0));
        end else begin
          exp = exp_q.pop_front();
          checkOutput("beat", 64'(act), 64'(exp));
        end
      end
    end
  end

  initial begin
    beat_t b0;
    beat_t b1;
    for (int i = 0; i < S; i++) begin
      drv_data[i]  = '0;
      drv_keep[i]  = '0;
      drv_user[i]  = '0;
      drv_valid[i] = 1'b0;
      drv_last[i]  = 1'b0;
    end
    rst      = 1'b1;
    m_tready = 1'b1;
    s_en     = '1;
`ifdef PCIE_DL_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 64'(m_tvalid), 64'(0));
    checkOutput("rst_grant", 64'(grant), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_tready", 64'(s_tready), 64'(0));
    checkOutput("rst_tdata", 64'(m_tdata), 64'(0));
    rst = 1'b0;
    tick();

    $display("[TB] priority: src0 vs src2 in same cycle");
    pushPacket(DL_SRC_ACKNAK, 1, 1);
    pushPacket(DL_SRC_TLP, 4, 2);
    b0 = mkBeat(DL_SRC_ACKNAK, 1, 0, 1);
    fork
      applyStimulus(DL_SRC_ACKNAK, 1, 1);
      applyStimulus(DL_SRC_TLP, 4, 2);
      begin
        tick();
        checkOutput("prio_grant", 64'(grant), 64'(3'b001));
        checkOutput("prio_busy", 64'(busy), 64'(1));
        tick();
        checkOutput("prio_mvalid", 64'(m_tvalid), 64'(1));
        checkOutput("prio_mdata", 64'(m_tdata), 64'(b0.data));
        tick();
        checkOutput("prio_grant2", 64'(grant), 64'(3'b100));
      end
    join
    settle();

    $display("[TB] atomicity: src0 arrives mid src2 packet");
    pushPacket(DL_SRC_TLP, 8, 3);
    pushPacket(DL_SRC_ACKNAK, 1, 4);
    fork
      applyStimulus(DL_SRC_TLP, 8, 3);
      begin
        repeat (4) tick();
        applyStimulus(DL_SRC_ACKNAK, 1, 4);
      end
      begin
        repeat (5) tick();
        checkOutput("atom_grant_hold", 64'(grant), 64'(3'b100));
        repeat (5) tick();
        checkOutput("atom_grant_next", 64'(grant), 64'(3'b001));
      end
    join
    settle();

    $display("[TB] starvation: src0 streaming, src2 waiting");
    pushPacket(DL_SRC_ACKNAK, 1, 10);
    pushPacket(DL_SRC_ACKNAK, 1, 11);
    pushPacket(DL_SRC_TLP, 2, 12);
    pushPacket(DL_SRC_ACKNAK, 1, 13);
    pushPacket(DL_SRC_ACKNAK, 1, 14);
    fork
      begin
        applyStimulus(DL_SRC_ACKNAK, 1, 10);
        applyStimulus(DL_SRC_ACKNAK, 1, 11);
        applyStimulus(DL_SRC_ACKNAK, 1, 13);
        applyStimulus(DL_SRC_ACKNAK, 1, 14);
      end
      applyStimulus(DL_SRC_TLP, 2, 12);
      begin
        repeat (5) tick();
        checkOutput("starve_grant", 64'(grant), 64'(3'b100));
        checkOutput("starve_src0_pending", 64'(s_tvalid[0]), 64'(1));
      end
    join
    settle();

    $display("[TB] backpressure mid-packet");
    pushPacket(DL_SRC_FC, 6, 20);
    b1 = mkBeat(DL_SRC_FC, 20, 1, 6);
    fork
      applyStimulus(DL_SRC_FC, 6, 20);
      begin
        repeat (3) tick();
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          tick();
          checkOutput("bp_mvalid", 64'(m_tvalid), 64'(1));
          checkOutput("bp_mdata", 64'(m_tdata), 64'(b1.data));
          checkOutput("bp_tready", 64'(s_tready), 64'(0));
        end
        m_tready = 1'b1;
      end
    join
    settle();

`ifdef PCIE_DL_SCHED_STATS_EN
    $display("[TB] statistics counters");
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pushPacket(DL_SRC_FC, 2, 30 + k);
      applyStimulus(DL_SRC_FC, 2, 30 + k);
    end
    for (int k = 0; k < 2; k++) begin
      pushPacket(DL_SRC_TLP, 1, 33 + k);
      applyStimulus(DL_SRC_TLP, 1, 33 + k);
    end
    settle();
    checkOutput("stat_cnt", 64'(stat_cnt), 64'({16'd2, 16'd3, 16'd0}));
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checkOutput("stat_clr", 64'(stat_cnt), 64'(0));
`endif

    $display("[TB] async reset mid-packet");
    pushPacket(DL_SRC_TLP, 8, 40);
    fork
      applyStimulus(DL_SRC_TLP, 8, 40);
      begin
        repeat (4) tick();
        checkOutput("pre_rst_busy", 64'(busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_tvalid", 64'(m_tvalid), 64'(0));
        checkOutput("async_rst_grant", 64'(grant), 64'(0));
        checkOutput("async_rst_tready", 64'(s_tready), 64'(0));
        checkOutput("async_rst_busy", 64'(busy), 64'(0));
      end
    join
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    pushPacket(DL_SRC_FC, 2, 41);
    applyStimulus(DL_SRC_FC, 2, 41);

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
    repeat (2) tick();
    checkOutput("drain", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
